hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides stall, freeze and flush per cycle from the ID-stage opcode/registers, the ID/EX load flag, the EX/MEM branch outcome and the data-memory ready handshake.
- Drives the write-enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Sits beside the control unit, downstream of instruction decode.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/hazard_detect.sv | 22 ++
 rtl/hazard_stall_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcodes used by decode and
// hazard logic, plus the pipeline sequencing states.
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] LW     = 6'b100011;
    localparam logic [5:0] SW     = 6'b101011;
    localparam logic [5:0] BEQ    = 6'b000100;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] ANDI   = 6'b001100;
    localparam logic [5:0] ORI    = 6'b001101;
    localparam logic [5:0] SLTI   = 6'b001010;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the ID stage and a lw in ID/EX.
module hazard_detect
    import mips_pkg::*;
(
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    output logic       load_use
);

    logic uses_rt;

    always_comb begin
        // Only these formats actually read rt as a source operand.
        uses_rt  = (id_opcode == R_TYPE) || (id_opcode == SW) || (id_opcode == BEQ);
        load_use = idex_memread && (idex_rt != 5'd0) &&
                   ((idex_rt == id_rs) || (uses_rt && (idex_rt == id_rt)));
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: per-cycle stall, freeze and flush decisions
// for the PC and the four pipeline registers, with memory-wait timeout.
module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              load_use;
    logic              freeze;
    logic              hold;
    logic              advance;

    hazard_detect u_hazard_detect (
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .load_use     (load_use)
    );

    assign freeze = mem_req && !mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        next_state   = state;
        wait_next    = wait_cnt;
        hold         = 1'b0;
        advance      = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        mem_error    = 1'b0;

        case (state)
            RUN: begin
                if (freeze) begin
                    hold       = 1'b1;
                    next_state = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    advance    = 1'b1;
                    next_state = RUN;
                    wait_next  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    hold       = 1'b1;
                    next_state = ERROR;
                end else begin
                    hold      = 1'b1;
                    wait_next = wait_cnt + 1'b1;
                end
            end
            default: begin
                hold      = 1'b1;
                mem_error = 1'b1;
            end
        endcase

        // A taken branch stays parked in EX/MEM while frozen, so it is only
        // acted on once the pipeline is allowed to advance.
        if (hold) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (advance && exmem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (advance && load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end

        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b0;
            idex_write   = 1'b0;
            idex_flush   = 1'b1;
            exmem_write  = 1'b0;
            exmem_flush  = 1'b0;
            memwb_bubble = 1'b1;
            mem_error    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic             exmem_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             exmem_flush;
    logic             memwb_bubble;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;

    hazard_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .id_opcode          (id_opcode),
        .id_rs              (id_rs),
        .id_rt              (id_rt),
        .idex_memread       (idex_memread),
        .idex_rt            (idex_rt),
        .exmem_branch_taken (exmem_branch_taken),
        .mem_req            (mem_req),
        .mem_ready          (mem_ready),
        .pc_write           (pc_write),
        .ifid_write         (ifid_write),
        .ifid_flush         (ifid_flush),
        .idex_write         (idex_write),
        .idex_flush         (idex_flush),
        .exmem_write        (exmem_write),
        .exmem_flush        (exmem_flush),
        .memwb_bubble       (memwb_bubble),
        .mem_error          (mem_error),
        .stall_cycles       (stall_cycles)
    );

    // Output vector: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, bubble, err}
    localparam logic [8:0] O_RST = 9'b0_0_0_0_1_0_0_1_0;
    localparam logic [8:0] O_DEF = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] O_LU  = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] O_BR  = 9'b1_1_1_1_1_1_1_0_0;
    localparam logic [8:0] O_FRZ = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] O_ERR = 9'b0_0_0_0_0_0_0_1_1;

    typedef struct {
        logic [8:0]       outs;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    logic [8:0] act;
    int tests = 0;
    int fails = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic rst_i, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                        input logic br, input logic req, input logic rdy,
                        input logic [8:0] eo, input int ec, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset              = rst_i;
        id_opcode          = op;
        id_rs              = rs;
        id_rt              = rt;
        idex_memread       = mr;
        idex_rt            = xrt;
        exmem_branch_taken = br;
        mem_req            = req;
        mem_ready          = rdy;
        e.outs = eo;
        e.cnt  = CNT_W'(ec);
        e.name = nm;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e = q.pop_front();
            act = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                   exmem_write, exmem_flush, memwb_bubble, mem_error};
            tests++;
            if (act !== m_e.outs) begin
                fails++;
                $display("FAIL %s outs actual=%b required=%b", m_e.name, act, m_e.outs);
            end
            tests++;
            if (stall_cycles !== m_e.cnt) begin
                fails++;
                $display("FAIL %s stall_cycles actual=%0d required=%0d",
                         m_e.name, stall_cycles, m_e.cnt);
            end
        end
    end

    initial begin
        reset = 1'b1; id_opcode = '0; id_rs = '0; id_rt = '0; idex_memread = 1'b0;
        idex_rt = '0; exmem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        // reset and release
        step(1, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, "reset");
        step(1, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, "reset_hold");
        step(0, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, "release");

        // load-use on rt of an R-type, then addi that does not read rt
        step(0, 6'b000000, 0, 5, 1, 5, 0, 0, 0, O_LU,  0, "lu_rtype");
        step(0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, O_DEF, 1, "lu_clear");
        step(0, 6'b001000, 3, 5, 1, 5, 0, 0, 0, O_DEF, 1, "addi_no_stall");
        step(0, 6'b000000, 0, 0, 1, 0, 0, 0, 0, O_DEF, 1, "rt_zero_no_stall");
        step(0, 6'b100011, 7, 0, 1, 7, 0, 0, 0, O_LU,  1, "lu_rs_lw");
        step(0, 6'b000000, 0, 5, 1, 5, 1, 0, 0, O_BR,  2, "branch_over_lu");
        step(0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, O_DEF, 2, "after_branch");

        // three-cycle memory freeze with a deferred branch
        step(1, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, "reset2");
        step(0, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, "release2");
        step(0, 6'o00, 0, 0, 0, 0, 1, 1, 0, O_FRZ, 0, "freeze1");
        step(0, 6'o00, 0, 0, 0, 0, 1, 1, 0, O_FRZ, 1, "freeze2");
        step(0, 6'o00, 0, 0, 0, 0, 1, 1, 0, O_FRZ, 2, "freeze3");
        step(0, 6'o00, 0, 0, 0, 0, 1, 1, 1, O_BR,  3, "release_branch");
        step(0, 6'b000000, 0, 5, 1, 5, 0, 0, 0, O_LU, 3, "back_in_run");
        step(0, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_DEF, 4, "idle");

        // reset during a wait leaves nothing pending
        step(0, 6'o00, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 4, "wait_a");
        step(0, 6'o00, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 5, "wait_b");
        step(1, 6'o00, 0, 0, 0, 0, 0, 1, 0, O_RST, 0, "reset_mid_wait");
        step(0, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, "no_pending");

        // timeout into sticky error
        for (int i = 0; i < 16; i++)
            step(0, 6'o00, 0, 0, 0, 0, 0, 1, 0, O_FRZ, i, "timeout_wait");
        step(0, 6'o00, 0, 0, 0, 0, 0, 1, 0, O_ERR, 15, "error_entry");
        step(0, 6'o00, 0, 0, 0, 0, 0, 1, 1, O_ERR, 15, "error_ready_ignored");
        step(0, 6'o00, 0, 0, 0, 0, 1, 0, 1, O_ERR, 15, "error_sticky");
        step(1, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, "error_reset");
        step(0, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, "error_cleared");

        // held load-use saturates the counter
        for (int i = 0; i < 20; i++)
            step(0, 6'b101011, 0, 9, 1, 9, 0, 0, 0, O_LU, (i > 15) ? 15 : i, "saturate");
        step(0, 6'o00, 0, 0, 0, 0, 0, 0, 0, O_DEF, 15, "saturated");

        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending actual=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
